// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipeline controller and the
// multi-cycle multiplier sequencer.
//   state_t    : multiplier sequencer states (IDLE, RUN, DONE), 2 bits
//   InsMUL/GHI/GLO : execute-stage opcodes that involve the multiplier
//   DEF_WIDTH  : default multiplier operand width
package ctrl_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] InsMUL = 4'b1101;
  localparam logic [3:0] InsGHI = 4'b1110;
  localparam logic [3:0] InsGLO = 4'b1111;

endpackage

// File: rtl/mult_sched_dp.sv
// mult_sched_dp: radix-2 shift-add multiplier datapath.
// Holds the operand, accumulator and HI/LO registers. One shift-add step is
// performed per cycle while step=1; the final step also writes the full
// product to HI/LO when commit=1.
// Optional feature macro: MUL_SIGNED_EN (two's complement operands via
// sign-magnitude conversion; unsigned multiply when undefined).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            latch operands, clear accumulator
//   step            perform one shift-add step
//   commit          write the product of the current (last) step to HI/LO
//   op_a, op_b      multiplicand, multiplier
//   hi, lo          HI/LO registers
module mult_sched_dp
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             commit,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mplier_in;

`ifdef MUL_SIGNED_EN
  logic sign;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign(input logic [2*WIDTH-1:0] p,
                                                  input logic neg);
    return neg ? (~p + 1'b1) : p;
  endfunction

  assign mcand_in  = abs_val(op_a);
  assign mplier_in = abs_val(op_b);
  assign result    = fix_sign(prod_next, sign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sign <= 1'b0;
    else if (load) sign <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
  end
`else
  assign mcand_in  = op_a;
  assign mplier_in = op_b;
  assign result    = prod_next;
`endif

  // Add stage: carry kept in sum[WIDTH]; shifting {carry, acc, mplier}
  // right by one gives the next accumulator and multiplier.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    prod_next = {sum, mplier[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
    end else if (step) begin
      acc    <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
    end
  end

  // HI/LO only change on the commit edge; intermediate accumulator values
  // never reach them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= result[2*WIDTH-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: sequencer and hazard controller for the multi-cycle
// multiplier. Accepts MUL issues, runs WIDTH shift-add steps, commits the
// 2*WIDTH-bit product to HI/LO, and requests a pipeline stall while busy and
// the execute stage needs the unit.
// Optional feature macro: MUL_SIGNED_EN (signed multiply, see mult_sched_dp).
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   MulStart   execute stage holds a MUL (level, held until accepted)
//   OpA, OpB   multiplicand / multiplier, sampled on acceptance
//   HiLoRead   execute stage holds GHI or GLO
//   StallReq   combinational stall request to the pipeline controller
//   Busy       multiply in progress
//   Done       one-cycle pulse after HI/LO commit
//   Hi, Lo     HI/LO registers
module mult_scheduler
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MulStart,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiLoRead,
  output logic             StallReq,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             load;
  logic             step;
  logic             commit;
  logic             last;

  assign last = (count == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // A MUL arriving during RUN is held by the stalled execute stage and is
  // picked up from DONE, giving back-to-back operation.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE, DONE: begin
        load       = MulStart;
        state_next = MulStart ? RUN : IDLE;
      end
      RUN: begin
        step   = 1'b1;
        commit = last;
        if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 count <= '0;
    else if (load)           count <= CNT_W'(WIDTH - 1);
    else if (step && !last)  count <= count - 1'b1;
  end

  assign Busy     = (state == RUN);
  assign Done     = (state == DONE);
  assign StallReq = (state == RUN) && (MulStart || HiLoRead);

  mult_sched_dp #(.WIDTH(WIDTH)) u_dp (
    .clk    (CLK),
    .rst    (RST),
    .load   (load),
    .step   (step),
    .commit (commit),
    .op_a   (OpA),
    .op_b   (OpB),
    .hi     (Hi),
    .lo     (Lo)
  );

endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed self-checking bench for mult_scheduler
// (WIDTH=16). Expected values are hand-computed products and cycle counts.
module tb_mult_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MulStart;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic        HiLoRead;
  logic        StallReq;
  logic        Busy;
  logic        Done;
  logic [15:0] Hi;
  logic [15:0] Lo;

  int checks   = 0;
  int failures = 0;

  mult_scheduler #(.WIDTH(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .MulStart (MulStart),
    .OpA      (OpA),
    .OpB      (OpB),
    .HiLoRead (HiLoRead),
    .StallReq (StallReq),
    .Busy     (Busy),
    .Done     (Done),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply and watch 20 cycles; k=1 is the cycle after the
  // acceptance edge. Returns busy cycle count, done pulse count and the
  // first cycle index with Done=1.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge CLK);
    MulStart = 1'b1; OpA = a; OpB = b;
    @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      MulStart = 1'b0;
      #1;
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
    end
  endtask

  int bn, dn, da;

  initial begin
    RST = 1'b1; MulStart = 1'b0; OpA = '0; OpB = '0; HiLoRead = 1'b0;
    #1;
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_stall", StallReq, 0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    // 3 x 5
    run_mul(16'd3, 16'd5, bn, dn, da);
    chk("u3x5_lo", Lo, 32'h000F);
    chk("u3x5_hi", Hi, 32'h0000);
    chk("u3x5_busy_cycles", bn, 16);
    chk("u3x5_done_pulses", dn, 1);
    chk("u3x5_done_cycle", da, 17);

    // 0xFFFF x 0xFFFF
    run_mul(16'hFFFF, 16'hFFFF, bn, dn, da);
    chk("max_hi", Hi, 32'hFFFE);
    chk("max_lo", Lo, 32'h0001);

    // HiLoRead together with MulStart in IDLE, then held from RUN cycle 3
    @(negedge CLK);
    MulStart = 1'b1; OpA = 16'd3; OpB = 16'd4; HiLoRead = 1'b1;
    #1;
    chk("idle_no_stall", StallReq, 0);
    chk("idle_read_old_lo", Lo, 32'h0001);
    @(posedge CLK);
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      MulStart = 1'b0;
      HiLoRead = (k >= 3);
      #1;
      if (k == 2)  chk("rd_stall_c2", StallReq, 0);
      if (k == 3)  chk("rd_stall_c3", StallReq, 1);
      if (k == 16) chk("rd_stall_last_run", StallReq, 1);
      if (k == 17) begin
        chk("rd_stall_done", StallReq, 0);
        chk("rd_done", Done, 1);
        chk("rd_new_lo", Lo, 32'h000C);
        chk("rd_new_hi", Hi, 32'h0000);
      end
    end
    HiLoRead = 1'b0;

    // Back-to-back: 0x10 x 0x10 then 7 x 9 held through RUN
    @(negedge CLK);
    MulStart = 1'b1; OpA = 16'h0010; OpB = 16'h0010;
    @(posedge CLK);
    for (int k = 1; k <= 36; k++) begin
      @(negedge CLK);
      if (k == 1) begin OpA = 16'd7; OpB = 16'd9; end
      if (k == 18) MulStart = 1'b0;
      #1;
      if (k == 1)  chk("b2b_stall_c1", StallReq, 1);
      if (k == 16) chk("b2b_stall_c16", StallReq, 1);
      if (k == 17) begin
        chk("b2b_first_done", Done, 1);
        chk("b2b_first_lo", Lo, 32'h0100);
        chk("b2b_stall_done", StallReq, 0);
      end
      if (k == 18) chk("b2b_rerun_busy", Busy, 1);
      if (k == 25) chk("b2b_lo_stable", Lo, 32'h0100);
      if (k == 33) chk("b2b_no_early_done", Done, 0);
      if (k == 34) begin
        chk("b2b_second_done", Done, 1);
        chk("b2b_second_lo", Lo, 32'h003F);
      end
    end

    // Reset during RUN aborts
    @(negedge CLK);
    MulStart = 1'b1; OpA = 16'h1234; OpB = 16'h0010;
    @(posedge CLK);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      MulStart = 1'b0;
    end
    RST = 1'b1;
    #1;
    chk("abort_hi", Hi, 0);
    chk("abort_lo", Lo, 0);
    chk("abort_busy", Busy, 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (k == 17) chk("abort_no_commit_lo", Lo, 0);
    end
    run_mul(16'd2, 16'd2, bn, dn, da);
    chk("after_abort_lo", Lo, 32'h0004);
    chk("after_abort_hi", Hi, 32'h0000);

    // 0xFFFD x 0x0005
    run_mul(16'hFFFD, 16'h0005, bn, dn, da);
`ifdef MUL_SIGNED_EN
    chk("neg_hi", Hi, 32'hFFFF);
`else
    chk("neg_hi", Hi, 32'h0004);
`endif
    chk("neg_lo", Lo, 32'hFFF1);
    chk("neg_done_cycle", da, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
